// File: rtl/cordic_hyp_seq_ctrl_pkg.sv
// Shared definitions for the hyperbolic CORDIC control sequencer:
// FSM state encoding, adder operand-select codes, mode constants and the
// hyperbolic repeat-iteration indices.
package cordic_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_PREX_I, S_PREX_W,
    S_PREY_I, S_PREY_W,
    S_CAPT,
    S_SHFT,
    S_ITX_I,  S_ITX_W,
    S_ITY_I,  S_ITY_W,
    S_ITZ_I,  S_ITZ_W,
    S_POST_I, S_POST_W,
    S_DONE,
    S_ERR
  } state_t;

  // Adder operand-select codes
  localparam logic [2:0] OP_PRE_X = 3'd0;  // T + 1.0
  localparam logic [2:0] OP_PRE_Y = 3'd1;  // T - 1.0
  localparam logic [2:0] OP_IT_X  = 3'd2;  // Xprev +/- Yshift
  localparam logic [2:0] OP_IT_Y  = 3'd3;  // Yprev +/- Xshift
  localparam logic [2:0] OP_IT_Z  = 3'd4;  // Zprev -/+ atanh[i]
  localparam logic [2:0] OP_POST  = 3'd5;  // final add into result

  localparam logic MODE_LN  = 1'b0;
  localparam logic MODE_EXP = 1'b1;

  // Hyperbolic CORDIC needs iterations 4, 13, 40 executed twice to converge
  localparam int unsigned REP_A = 4;
  localparam int unsigned REP_B = 13;
  localparam int unsigned REP_C = 40;

  function automatic logic is_rep_idx(input int unsigned i);
    return (i == REP_A) || (i == REP_B) || (i == REP_C);
  endfunction

endpackage

// File: rtl/cordic_hyp_seq_ctrl_issuer.sv
// fp_add_issuer: issue/wait engine for the shared FP adder.
//   go        : high for the single ISSUE cycle of an add; forwarded as START_ADD
//   ACK_ADD   : adder result valid; only honoured while waiting
//   START_ADD : one-cycle adder start pulse
//   ack_hit   : ACK_ADD seen while waiting (the step's enable cycle)
//   tmo       : ACK_TMO wait cycles elapsed without ACK (never when ACK_TMO == 0)
module fp_add_issuer
  import cordic_ctrl_pkg::*;
#(
  parameter int ACK_TMO = 64,
  parameter int TMO_W   = 7
) (
  input  logic CLK,
  input  logic RST_LN,
  input  logic go,
  input  logic ACK_ADD,
  output logic START_ADD,
  output logic ack_hit,
  output logic tmo
);

  // Last permitted wait cycle index; tmo fires when it passes without an ACK
  localparam logic [TMO_W-1:0] TMO_LAST = (ACK_TMO == 0) ? '0 : TMO_W'(ACK_TMO - 1);

  logic             waiting;
  logic [TMO_W-1:0] cnt;

  assign START_ADD = go;
  assign ack_hit   = waiting & ACK_ADD;
  assign tmo       = (ACK_TMO != 0) && waiting && !ACK_ADD && (cnt == TMO_LAST);

  always_ff @(posedge CLK or posedge RST_LN) begin
    if (RST_LN) begin
      waiting <= 1'b0;
      cnt     <= '0;
    end else if (go) begin
      waiting <= 1'b1;
      cnt     <= '0;
    end else if (waiting) begin
      if (ack_hit || tmo) begin
        waiting <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_hyp_seq_ctrl.sv
// cordic_hyp_seq_ctrl: control sequencer for the iterative hyperbolic CORDIC
// datapath around a shared FP add/subtract unit. LN runs in vectoring mode,
// EXP in rotation mode.
//   CLK, RST_LN       : clock, async active-high reset
//   START, MODE, CLR  : start (IDLE only), 0=LN/1=EXP, DONE/ERR -> IDLE
//   ACK_ADD           : adder result valid
//   D_SIGN_Y/Z        : datapath sign bits used for direction selection
//   RST_DP, LOAD_INIT : datapath clear / EXP initial load
//   SEL_OP, ADD_SUBT, START_ADD : adder operand select, op, start pulse
//   EN_X/Y/Z/PREV/SHIFT/RESULT  : register enables
//   ITER_IDX          : shift amount and atanh ROM address
//   BUSY, DONE, ERR   : status
module cordic_hyp_seq_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int N_ITER    = 16,
  parameter int ITER_W    = 6,
  parameter int REPEAT_EN = 1,
  parameter int ACK_TMO   = 64,
  parameter int TMO_W     = 7
) (
  input  logic              CLK,
  input  logic              RST_LN,
  input  logic              START,
  input  logic              MODE,
  input  logic              CLR,
  input  logic              ACK_ADD,
  input  logic              D_SIGN_Y,
  input  logic              D_SIGN_Z,
  output logic              RST_DP,
  output logic              LOAD_INIT,
  output logic [2:0]        SEL_OP,
  output logic              ADD_SUBT,
  output logic              START_ADD,
  output logic              EN_X,
  output logic              EN_Y,
  output logic              EN_Z,
  output logic              EN_PREV,
  output logic              EN_SHIFT,
  output logic              EN_RESULT,
  output logic [ITER_W-1:0] ITER_IDX,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  state_t            state, nxt;
  logic [ITER_W-1:0] iter;
  logic              rep_flag;
  logic              dir;       // 1 = d is +1
  logic              mode_r;
  logic              go, ack_hit, tmo;
  logic              rep_now, last;

  fp_add_issuer #(
    .ACK_TMO(ACK_TMO),
    .TMO_W  (TMO_W)
  ) u_issuer (
    .CLK      (CLK),
    .RST_LN   (RST_LN),
    .go       (go),
    .ACK_ADD  (ACK_ADD),
    .START_ADD(START_ADD),
    .ack_hit  (ack_hit),
    .tmo      (tmo)
  );

  // Repeat the current index once more before moving on
  assign rep_now = (REPEAT_EN != 0) && !rep_flag && is_rep_idx(32'(iter));
  assign last    = (iter == ITER_W'(N_ITER));

  always_ff @(posedge CLK or posedge RST_LN) begin
    if (RST_LN) state <= S_IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge CLK or posedge RST_LN) begin
    if (RST_LN) begin
      iter     <= '0;
      rep_flag <= 1'b0;
      dir      <= 1'b0;
      mode_r   <= 1'b0;
    end else begin
      if (state == S_IDLE && START) begin
        iter     <= ITER_W'(1);
        rep_flag <= 1'b0;
        mode_r   <= MODE;
      end
      if (state == S_CAPT)
        dir <= (mode_r == MODE_EXP) ? ~D_SIGN_Z : D_SIGN_Y;
      // Iteration bookkeeping happens on the IT_Z acknowledge (no separate NEXT cycle)
      if (state == S_ITZ_W && ack_hit) begin
        if (rep_now) begin
          rep_flag <= 1'b1;
        end else if (!last) begin
          iter     <= iter + 1'b1;
          rep_flag <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    nxt       = state;
    go        = 1'b0;
    RST_DP    = 1'b0;
    LOAD_INIT = 1'b0;
    SEL_OP    = 3'd0;
    ADD_SUBT  = 1'b0;
    EN_X      = 1'b0;
    EN_Y      = 1'b0;
    EN_Z      = 1'b0;
    EN_PREV   = 1'b0;
    EN_SHIFT  = 1'b0;
    EN_RESULT = 1'b0;
    DONE      = 1'b0;
    ERR       = 1'b0;
    case (state)
      S_IDLE:   if (START) nxt = S_INIT;
      S_INIT: begin
        RST_DP = 1'b1;
        nxt    = (mode_r == MODE_EXP) ? S_LOAD : S_PREX_I;
      end
      S_LOAD: begin
        LOAD_INIT = 1'b1;
        EN_X      = 1'b1;
        EN_Y      = 1'b1;
        EN_Z      = 1'b1;
        nxt       = S_CAPT;
      end
      S_PREX_I: begin SEL_OP = OP_PRE_X; go = 1'b1; nxt = S_PREX_W; end
      S_PREX_W: begin
        SEL_OP = OP_PRE_X;
        EN_X   = ack_hit;
        if (ack_hit) nxt = S_PREY_I;
      end
      S_PREY_I: begin SEL_OP = OP_PRE_Y; ADD_SUBT = 1'b1; go = 1'b1; nxt = S_PREY_W; end
      S_PREY_W: begin
        SEL_OP   = OP_PRE_Y;
        ADD_SUBT = 1'b1;
        EN_Y     = ack_hit;
        if (ack_hit) nxt = S_CAPT;
      end
      S_CAPT:   begin EN_PREV = 1'b1; nxt = S_SHFT; end
      S_SHFT:   begin EN_SHIFT = 1'b1; nxt = S_ITX_I; end
      S_ITX_I:  begin SEL_OP = OP_IT_X; ADD_SUBT = ~dir; go = 1'b1; nxt = S_ITX_W; end
      S_ITX_W: begin
        SEL_OP   = OP_IT_X;
        ADD_SUBT = ~dir;
        EN_X     = ack_hit;
        if (ack_hit) nxt = S_ITY_I;
      end
      S_ITY_I:  begin SEL_OP = OP_IT_Y; ADD_SUBT = ~dir; go = 1'b1; nxt = S_ITY_W; end
      S_ITY_W: begin
        SEL_OP   = OP_IT_Y;
        ADD_SUBT = ~dir;
        EN_Y     = ack_hit;
        if (ack_hit) nxt = S_ITZ_I;
      end
      S_ITZ_I:  begin SEL_OP = OP_IT_Z; ADD_SUBT = dir; go = 1'b1; nxt = S_ITZ_W; end
      S_ITZ_W: begin
        SEL_OP   = OP_IT_Z;
        ADD_SUBT = dir;
        EN_Z     = ack_hit;
        if (ack_hit) nxt = (rep_now || !last) ? S_CAPT : S_POST_I;
      end
      S_POST_I: begin SEL_OP = OP_POST; go = 1'b1; nxt = S_POST_W; end
      S_POST_W: begin
        SEL_OP    = OP_POST;
        EN_RESULT = ack_hit;
        if (ack_hit) nxt = S_DONE;
      end
      S_DONE: begin
        DONE = 1'b1;
        if (CLR) nxt = S_IDLE;
      end
      S_ERR: begin
        DONE = 1'b1;
        ERR  = 1'b1;
        if (CLR) nxt = S_IDLE;
      end
      default:  nxt = S_IDLE;
    endcase
    // tmo is only ever raised while an add is waiting
    if (tmo) nxt = S_ERR;
    BUSY     = !(state inside {S_IDLE, S_DONE, S_ERR});
    ITER_IDX = BUSY ? iter : '0;
  end

endmodule

// File: tb/tb_cordic_hyp_seq_ctrl.sv
// Bench for cordic_hyp_seq_ctrl: a cycle table for the opening of an LN run,
// then responder-driven full runs on a default instance (N_ITER=16, repeats)
// and a small instance (N_ITER=8, no repeats).
module tb_cordic_hyp_seq_ctrl;

  logic CLK = 1'b0;
  logic RST_LN;
  logic [1:0] start, mode, clr, ack, sy, sz;
  logic [1:0] rst_dp, load_init, add_subt, start_add, en_x, en_y, en_z;
  logic [1:0] en_prev, en_shift, en_result, busy, done, err;
  logic [1:0][2:0] sel_op;
  logic [1:0][5:0] iter_idx;

  always #5 CLK = ~CLK;

  cordic_hyp_seq_ctrl dut0 (
    .CLK(CLK), .RST_LN(RST_LN), .START(start[0]), .MODE(mode[0]), .CLR(clr[0]),
    .ACK_ADD(ack[0]), .D_SIGN_Y(sy[0]), .D_SIGN_Z(sz[0]), .RST_DP(rst_dp[0]),
    .LOAD_INIT(load_init[0]), .SEL_OP(sel_op[0]), .ADD_SUBT(add_subt[0]),
    .START_ADD(start_add[0]), .EN_X(en_x[0]), .EN_Y(en_y[0]), .EN_Z(en_z[0]),
    .EN_PREV(en_prev[0]), .EN_SHIFT(en_shift[0]), .EN_RESULT(en_result[0]),
    .ITER_IDX(iter_idx[0]), .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0])
  );

  cordic_hyp_seq_ctrl #(.N_ITER(8), .REPEAT_EN(0)) dut1 (
    .CLK(CLK), .RST_LN(RST_LN), .START(start[1]), .MODE(mode[1]), .CLR(clr[1]),
    .ACK_ADD(ack[1]), .D_SIGN_Y(sy[1]), .D_SIGN_Z(sz[1]), .RST_DP(rst_dp[1]),
    .LOAD_INIT(load_init[1]), .SEL_OP(sel_op[1]), .ADD_SUBT(add_subt[1]),
    .START_ADD(start_add[1]), .EN_X(en_x[1]), .EN_Y(en_y[1]), .EN_Z(en_z[1]),
    .EN_PREV(en_prev[1]), .EN_SHIFT(en_shift[1]), .EN_RESULT(en_result[1]),
    .ITER_IDX(iter_idx[1]), .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1])
  );

  localparam logic [11:0] F_RST = 12'h800, F_LD = 12'h400, F_SA = 12'h200, F_EX = 12'h100;
  localparam logic [11:0] F_EY = 12'h080, F_EZ = 12'h040, F_PV = 12'h020, F_SH = 12'h010;
  localparam logic [11:0] F_BZ = 12'h004;

  typedef struct {
    logic       st, ak, sy;
    logic [11:0] fl;
    logic [2:0]  sel;
    logic        sub;
    logic [5:0]  it;
  } vec_t;

  int total = 0, bad = 0, cyc = 0;
  bit auto_en = 0;
  int dly_max[2], cnt[2], n_sa[2], n_post[2], n_load[2], n_rst[2], viol[2], dir_bad[2], n_en[2];
  int t_init[2], t_done[2], t_hold[2];
  bit arm[2], hold[2], hold_trig[2], glitch[2], ack_real[2], prev_sa[2], cap_dir[2];
  int itq0[$], itq1[$];

  function automatic logic [21:0] outv(input int k);
    return {rst_dp[k], load_init[k], start_add[k], en_x[k], en_y[k], en_z[k], en_prev[k],
            en_shift[k], en_result[k], busy[k], done[k], err[k], sel_op[k], add_subt[k], iter_idx[k]};
  endfunction

  function automatic vec_t mk(input logic st, ak, s, input logic [11:0] fl,
                              input logic [2:0] sel, input logic sub, input logic [5:0] it);
    vec_t v;
    v.st = st; v.ak = ak; v.sy = s; v.fl = fl; v.sel = sel; v.sub = sub; v.it = it;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      n_sa[k] = 0; n_post[k] = 0; n_load[k] = 0; n_rst[k] = 0; viol[k] = 0; dir_bad[k] = 0;
      n_en[k] = 0; t_init[k] = -1; t_done[k] = -1; t_hold[k] = -1;
      arm[k] = 0; cnt[k] = 0; hold[k] = 0; prev_sa[k] = 0;
    end
    itq0.delete(); itq1.delete();
  endtask

  // One clock: drive responder inputs at +1 after the edge, observe at +2.
  task automatic step();
    @(posedge CLK); #1; cyc++;
    for (int k = 0; k < 2; k++) begin
      ack_real[k] = 0; ack[k] = 0;
      if (auto_en) begin
        sy[k] = ~sy[k];
        sz[k] = 1'($urandom_range(0, 1));
        if (arm[k]) begin
          if (!hold[k]) begin
            if (cnt[k] == 0) begin ack_real[k] = 1; arm[k] = 0; end
            else cnt[k]--;
          end
        end else if (glitch[k] && $urandom_range(0, 3) == 0) ack[k] = 1'b1;
        if (start_add[k]) begin
          arm[k] = 1;
          cnt[k] = (dly_max[k] == 0) ? 0 : int'($urandom_range(0, dly_max[k]));
          if (hold_trig[k] && sel_op[k] == 3 && iter_idx[k] == 3) begin
            hold[k] = 1; t_hold[k] = cyc;
          end
        end
        ack[k] = ack[k] | ack_real[k];
      end
    end
    #1;
    if (auto_en) begin
      for (int k = 0; k < 2; k++) begin
        if (rst_dp[k]) begin n_rst[k]++; if (t_init[k] < 0) t_init[k] = cyc; end
        if ((done[k] | err[k]) && t_done[k] < 0) t_done[k] = cyc;
        if (start_add[k]) begin
          n_sa[k]++;
          if (prev_sa[k]) viol[k]++;
          if (sel_op[k] == 5) n_post[k]++;
          if (sel_op[k] == 2 && add_subt[k] != ~cap_dir[k]) dir_bad[k]++;
          if (sel_op[k] == 4 && add_subt[k] != cap_dir[k]) dir_bad[k]++;
        end
        prev_sa[k] = start_add[k];
        if ((en_x[k] | en_y[k] | en_z[k] | en_result[k]) && !ack_real[k] && !load_init[k]) viol[k]++;
        if (en_prev[k]) begin
          cap_dir[k] = mode[k] ? ~sz[k] : sy[k];
          if (k == 0) itq0.push_back(int'(iter_idx[k])); else itq1.push_back(int'(iter_idx[k]));
        end
        if (load_init[k] && en_x[k] && en_y[k] && en_z[k]) n_load[k]++;
        if (en_x[k] | en_y[k] | en_z[k] | en_prev[k] | en_shift[k] | en_result[k] |
            load_init[k] | rst_dp[k] | start_add[k]) n_en[k]++;
      end
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    start = start | m;
    step();
    start = start & ~m;
  endtask

  task automatic do_clr(input logic [1:0] m);
    clr = clr | m;
    step();
    clr = clr & ~m;
  endtask

  task automatic run(input int budget, input logic [1:0] act, input string nm);
    int n = 0;
    while (n < budget && ((act[0] && !(done[0] | err[0])) || (act[1] && !(done[1] | err[1])))) begin
      step();
      n++;
    end
    chk({nm, " finished in budget"}, n < budget, 1);
  endtask

  task automatic chk_seq(input int k, input int n, input bit rep, input string nm);
    int q[$], e[$], m;
    if (k == 0) q = itq0; else q = itq1;
    for (int i = 1; i <= n; i++) begin
      e.push_back(i);
      if (rep && (i == 4 || i == 13 || i == 40)) e.push_back(i);
    end
    chk({nm, " iter count"}, q.size(), e.size());
    m = 0;
    for (int i = 0; i < e.size() && i < q.size(); i++) if (q[i] != e[i]) m++;
    chk({nm, " iter seq errors"}, m, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[19];
    int e0, s0;
    start = '0; mode = '0; clr = '0; ack = '0; sy = '0; sz = '0;
    dly_max = '{0, 0}; glitch = '{0, 0}; hold_trig = '{0, 0};
    clear_stats();

    // Opening of an LN run, cycle by cycle; ACK glitches in CAPT/SHFT/ISSUE
    tbl[0]  = mk(1, 0, 0, 12'h000,      0, 0, 0);
    tbl[1]  = mk(0, 0, 0, F_RST | F_BZ, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, F_SA | F_BZ,  0, 0, 1);
    tbl[3]  = mk(0, 1, 0, F_EX | F_BZ,  0, 0, 1);
    tbl[4]  = mk(0, 0, 0, F_SA | F_BZ,  1, 1, 1);
    tbl[5]  = mk(0, 0, 0, F_BZ,         1, 1, 1);
    tbl[6]  = mk(0, 1, 0, F_EY | F_BZ,  1, 1, 1);
    tbl[7]  = mk(0, 1, 1, F_PV | F_BZ,  0, 0, 1);
    tbl[8]  = mk(0, 1, 0, F_SH | F_BZ,  0, 0, 1);
    tbl[9]  = mk(0, 1, 0, F_SA | F_BZ,  2, 0, 1);
    tbl[10] = mk(0, 0, 0, F_BZ,         2, 0, 1);
    tbl[11] = mk(0, 1, 0, F_EX | F_BZ,  2, 0, 1);
    tbl[12] = mk(0, 0, 0, F_SA | F_BZ,  3, 0, 1);
    tbl[13] = mk(0, 1, 0, F_EY | F_BZ,  3, 0, 1);
    tbl[14] = mk(0, 0, 0, F_SA | F_BZ,  4, 1, 1);
    tbl[15] = mk(0, 1, 0, F_EZ | F_BZ,  4, 1, 1);
    tbl[16] = mk(0, 0, 0, F_PV | F_BZ,  0, 0, 2);
    tbl[17] = mk(0, 0, 0, F_SH | F_BZ,  0, 0, 2);
    tbl[18] = mk(0, 0, 0, F_SA | F_BZ,  2, 1, 2);

    RST_LN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset outs dut0", outv(0), 0);
    chk("reset outs dut1", outv(1), 0);
    RST_LN = 1'b0;

    for (int r = 0; r < 19; r++) begin
      @(posedge CLK); #1;
      start[0] = tbl[r].st; ack[0] = tbl[r].ak; sy[0] = tbl[r].sy;
      #1;
      chk($sformatf("vec%0d", r), outv(0), {tbl[r].fl, tbl[r].sel, tbl[r].sub, tbl[r].it});
    end
    start[0] = 0; ack[0] = 0;
    RST_LN = 1'b1; #1; RST_LN = 1'b0;
    chk("abort by reset busy", busy[0], 0);

    // Zero-wait LN on dut0 and EXP (N_ITER=8, no repeats) on dut1 together
    auto_en = 1;
    step();
    clear_stats();
    mode = 2'b10;
    pulse_start(2'b11);
    run(2000, 2'b11, "zw");
    chk("ln adds", n_sa[0], 57);
    chk("ln latency", t_done[0] - t_init[0], 151);  // DONE is the 152nd cycle counting INIT as 1
    chk("ln dir errors", dir_bad[0], 0);
    chk("ln enable viol", viol[0], 0);
    chk("ln posts", n_post[0], 1);
    chk_seq(0, 16, 1, "ln");
    chk("exp8 adds", n_sa[1], 25);
    chk("exp8 load cycles", n_load[1], 1);
    chk("exp8 posts", n_post[1], 1);
    chk("exp8 latency", t_done[1] - t_init[1], 68);
    chk("exp8 dir errors", dir_bad[1], 0);
    chk("exp8 enable viol", viol[1], 0);
    chk_seq(1, 8, 0, "exp8");

    // DONE held without CLR: no activity
    e0 = n_en[0]; s0 = n_sa[0];
    repeat (20) step();
    chk("done hold activity", n_en[0], e0);
    chk("done hold starts", n_sa[0], s0);
    chk("done held", done[0], 1);

    // CLR then START on the next cycle -> new EXP op begins with RST_DP
    do_clr(2'b01);
    clear_stats();
    mode[0] = 1'b1;
    start[0] = 1'b1;
    chk("after clr idle", {busy[0], done[0]}, 0);
    step();
    start[0] = 1'b0;
    chk("restart rst_dp", rst_dp[0], 1);
    run(2000, 2'b01, "exp16");
    chk("exp16 latency", t_done[0] - t_init[0], 148);
    chk("exp16 adds", n_sa[0], 55);
    chk("exp16 load cycles", n_load[0], 1);
    chk("exp16 dir errors", dir_bad[0], 0);

    // Random ACK delays, ACK glitches, START and CLR while busy
    do_clr(2'b01);
    clear_stats();
    dly_max[0] = 10; glitch[0] = 1; mode[0] = 1'b0;
    pulse_start(2'b01);
    repeat (30) step();
    start[0] = 1'b1; clr[0] = 1'b1;
    step();
    start[0] = 1'b0; clr[0] = 1'b0;
    run(6000, 2'b01, "rnd");
    chk("rnd init count", n_rst[0], 1);
    chk("rnd adds", n_sa[0], 57);
    chk("rnd posts", n_post[0], 1);
    chk("rnd enable viol", viol[0], 0);
    chk("rnd dir errors", dir_bad[0], 0);
    chk("rnd err", err[0], 0);
    chk_seq(0, 16, 1, "rnd");

    // ACK withheld at IT_Y of i=3 -> timeout
    do_clr(2'b01);
    clear_stats();
    dly_max[0] = 0; glitch[0] = 0; hold_trig[0] = 1;
    pulse_start(2'b01);
    run(3000, 2'b01, "tmo");
    chk("tmo err/done/busy", {err[0], done[0], busy[0]}, 3'b110);
    chk("tmo delay", t_done[0] - t_hold[0], 65);
    do_clr(2'b01);
    chk("tmo clr idle", outv(0), 0);
    hold_trig[0] = 0;
    clear_stats();
    pulse_start(2'b01);
    run(2000, 2'b01, "post-tmo");
    chk("post-tmo adds", n_sa[0], 57);
    chk("post-tmo err", {done[0], err[0]}, 2'b10);

    // Reset asserted during iteration 7
    do_clr(2'b01);
    clear_stats();
    pulse_start(2'b01);
    begin
      int n = 0;
      while (!(en_prev[0] && iter_idx[0] == 7) && n < 500) begin step(); n++; end
      chk("reach iter 7", n < 500, 1);
    end
    RST_LN = 1'b1;
    #1;
    chk("mid reset outs dut0", outv(0), 0);
    chk("mid reset outs dut1", outv(1), 0);
    clear_stats();
    step();
    RST_LN = 1'b0;
    repeat (3) step();
    chk("after reset starts", n_sa[0], 0);
    chk("after reset busy", busy[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
